// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative HI/LO multiply/divide unit.
// Divider support is enabled by defining MULDIV_DIV_EN.
package muldiv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Magnitude of x; only negates when the operation treats operands as signed.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration: add-shift for multiply, subtract-restore for divide.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_iter
  import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
  input  logic            i_div,
`endif
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_m,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN:0] w_sum;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0] w_shl;
  logic [XLEN:0] w_diff;
`endif

  always_comb begin
    // Multiply: {acc,q} holds partial product above the unconsumed multiplier bits.
    w_sum = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : '0);
    o_acc = w_sum[XLEN:1];
    o_q   = {w_sum[0], i_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    w_shl  = {i_acc, i_q[XLEN-1]};
    w_diff = w_shl - {1'b0, i_m};
    if (i_div) begin
      // Remainder stays below the divisor, so bit XLEN of the difference is the borrow.
      if (!w_diff[XLEN]) begin
        o_acc = w_diff[XLEN-1:0];
        o_q   = {i_q[XLEN-2:0], 1'b1};
      end else begin
        o_acc = w_shl[XLEN-1:0];
        o_q   = {i_q[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_exe.sv
// Iterative HI/LO multiply/divide execute unit with MTHI/MTLO writes and cancel.
// Define MULDIV_DIV_EN to include DIV/DIVU; otherwise they complete immediately as no-ops.
module muldiv_exe
  import muldiv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            cancel,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_q;
  logic [XLEN-1:0]  r_m;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic             r_sgn;
  logic             r_a_neg;
  logic             r_b_neg;
  logic             r_busy;
  logic             r_done;
`ifdef MULDIV_DIV_EN
  logic             r_div;
  logic             r_div0;
  logic [XLEN-1:0]  r_rs;
`endif

  logic [XLEN-1:0]   w_acc_nxt;
  logic [XLEN-1:0]   w_q_nxt;
  logic [XLEN-1:0]   w_hi_fix;
  logic [XLEN-1:0]   w_lo_fix;
  logic [2*XLEN-1:0] w_prod;
  logic              w_neg;
  logic              w_sgn;
  logic              w_launch;

  assign w_sgn = is_signed_op(op);
`ifdef MULDIV_DIV_EN
  assign w_launch = 1'b1;
`else
  assign w_launch = !is_div_op(op);
`endif

  muldiv_iter u_iter (
`ifdef MULDIV_DIV_EN
    .i_div (r_div),
`endif
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_m   (r_m),
    .o_acc (w_acc_nxt),
    .o_q   (w_q_nxt)
  );

  always_comb begin
    w_prod = {r_acc, r_q};
    w_neg  = r_sgn & (r_a_neg ^ r_b_neg);
    {w_hi_fix, w_lo_fix} = w_neg ? (~w_prod + 64'd1) : w_prod;
`ifdef MULDIV_DIV_EN
    // After division acc holds the remainder magnitude and q the quotient magnitude.
    if (r_div) begin
      if (r_div0) begin
        w_hi_fix = r_rs;
        w_lo_fix = '1;
      end else begin
        w_lo_fix = w_neg ? (~r_q + 32'd1) : r_q;
        w_hi_fix = (r_sgn & r_a_neg) ? (~r_acc + 32'd1) : r_acc;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sgn   <= 1'b0;
      r_a_neg <= 1'b0;
      r_b_neg <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_div   <= 1'b0;
      r_div0  <= 1'b0;
      r_rs    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_launch) begin
              r_acc   <= '0;
              r_q     <= mag(rs_data, w_sgn);
              r_m     <= mag(rt_data, w_sgn);
              r_sgn   <= w_sgn;
              r_a_neg <= rs_data[XLEN-1];
              r_b_neg <= rt_data[XLEN-1];
              r_cnt   <= CNT_W'(ITER_COUNT - 1);
`ifdef MULDIV_DIV_EN
              r_div   <= is_div_op(op);
              r_div0  <= (rt_data == '0);
              r_rs    <= rs_data;
`endif
              r_state <= ST_CALC;
              r_busy  <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        ST_CALC: begin
          if (cancel) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            if (r_cnt == '0) begin
              r_state <= ST_FIX;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (!cancel) begin
            r_hi   <= w_hi_fix;
            r_lo   <= w_lo_fix;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_muldiv_exe.sv
// Directed plus randomized bench for muldiv_exe against an arithmetic reference model.
// Expectations for DIV/DIVU follow MULDIV_DIV_EN.
module tb_muldiv_exe;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic        cancel  = 1'b0;
  logic        hi_we   = 1'b0;
  logic        lo_we   = 1'b0;
  logic [1:0]  op      = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] wdata   = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  muldiv_exe dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .cancel  (cancel),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {HI,LO} after the operation, given the previous HI/LO.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ph,
                                        input logic [31:0] pl);
    longint sa, sb;
    int     ia, ib, iq, ir;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    if (o == MULT) begin
      r = sa * sb;
    end else if (o == MULTU) begin
      r = {32'd0, a} * {32'd0, b};
    end else if (!DIV_EN) begin
      r = {ph, pl};
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFFFFFF};
    end else if (o == DIVU) begin
      r = {a % b, a / b};
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      r = {32'd0, 32'h80000000};
    end else begin
      iq = ia / ib;
      ir = ia % ib;
      r = {ir, iq};
    end
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] exp;
    int lat;
    int bad;
    exp = model(o, a, b, m_hi, m_lo);
    lat = (o[1] && !DIV_EN) ? 1 : 34;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    bad = 0;
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k == 1) begin
        start = 1'b0; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
      end
      if (busy !== 1'(k < lat)) bad++;
      if (done !== 1'(k == lat)) bad++;
    end
    chk({tag, " timing"}, 64'(bad), 64'd0);
    chk({tag, " hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
    chk({tag, " lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    tick();
    chk({tag, " done_once"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b, w;
    logic [63:0] exp;
    int seen;

    tick();
    tick();
    chk("rst hi", {32'd0, hi}, 64'd0);
    chk("rst lo", {32'd0, lo}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    reset = 1'b0;

    hi_we = 1'b1; wdata = 32'h12345678;
    tick();
    hi_we = 1'b0; m_hi = 32'h12345678;
    chk("mthi", {32'd0, hi}, {32'd0, m_hi});
    chk("mthi lo kept", {32'd0, lo}, 64'd0);

    w = $urandom;
    hi_we = 1'b1; lo_we = 1'b1; wdata = w;
    tick();
    hi_we = 1'b0; lo_we = 1'b0; m_hi = w; m_lo = w;
    chk("mthi_mtlo hi", {32'd0, hi}, {32'd0, w});
    chk("mthi_mtlo lo", {32'd0, lo}, {32'd0, w});

    w = $urandom;
    cancel = 1'b1; lo_we = 1'b1; wdata = w;
    tick();
    cancel = 1'b0; lo_we = 1'b0; m_lo = w;
    chk("idle cancel mtlo", {32'd0, lo}, {32'd0, w});

    run_op("multu max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu max const", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op("mult neg", MULT, 32'hFFFFFFFD, 32'h00000007);
    chk("mult neg const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op("div neg", DIV, 32'hFFFFFFF9, 32'h00000002);
    if (DIV_EN) chk("div neg const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu zero", DIVU, 32'h00000064, 32'h00000000);
    if (DIV_EN) chk("divu zero const", {hi, lo}, 64'h00000064_FFFFFFFF);
    run_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF);
    run_op("div zero", DIV, 32'hFFFFFF00, 32'h00000000);
    run_op("div mix", DIV, 32'h00000007, 32'hFFFFFFFE);
    run_op("mult min", MULT, 32'h80000000, 32'h80000000);

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), a, b);
    end

    // Coincident MTHI with start, and MTHI while busy, must both be dropped.
    a = $urandom; b = $urandom;
    exp = model(MULTU, a, b, m_hi, m_lo);
    op = MULTU; rs_data = a; rt_data = b; start = 1'b1; cancel = 1'b1;
    hi_we = 1'b1; wdata = ~m_hi;
    tick();
    start = 1'b0; cancel = 1'b0; hi_we = 1'b0;
    chk("start w/ idle cancel busy", {63'd0, busy}, 64'd1);
    chk("mthi w/ start ignored", {32'd0, hi}, {32'd0, m_hi});
    hi_we = 1'b1; lo_we = 1'b1; wdata = ~m_lo;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi busy ignored", {hi, lo}, {m_hi, m_lo});
    for (int k = 3; k <= 33; k++) tick();
    tick();
    chk("after ignored mthi done", {63'd0, done}, 64'd1);
    chk("after ignored mthi res", {hi, lo}, exp);
    m_hi = exp[63:32]; m_lo = exp[31:0];
    tick();

    // Restart while busy is ignored; cancel in CALC aborts with no result.
    seen = 0;
    op = MULTU; rs_data = $urandom; rt_data = $urandom; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 5; k++) begin tick(); seen += int'(done); end
    op = MULT; rs_data = $urandom; start = 1'b1;
    tick();
    start = 1'b0; seen += int'(done);
    for (int k = 7; k <= 10; k++) begin tick(); seen += int'(done); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0; seen += int'(done);
    chk("cancel calc busy", {63'd0, busy}, 64'd0);
    for (int k = 0; k < 40; k++) begin tick(); seen += int'(done) + int'(busy); end
    chk("cancel calc no done", 64'(seen), 64'd0);
    chk("cancel calc hilo", {hi, lo}, {m_hi, m_lo});

    // Cancel arriving in the final cycle overrides the write-back.
    op = MULT; rs_data = $urandom; rt_data = $urandom; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 33; k++) tick();
    chk("fix busy", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel fix done", {63'd0, done}, 64'd0);
    chk("cancel fix busy", {63'd0, busy}, 64'd0);
    chk("cancel fix hilo", {hi, lo}, {m_hi, m_lo});

    run_op("recover", MULT, $urandom, $urandom);

    // Reset mid-CALC clears everything and suppresses done.
    op = MULTU; rs_data = 32'hFFFFFFFF; rt_data = 32'h3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 20; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; m_hi = '0; m_lo = '0;
    chk("calc rst hilo", {hi, lo}, 64'd0);
    chk("calc rst busy", {63'd0, busy}, 64'd0);
    chk("calc rst done", {63'd0, done}, 64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin tick(); seen += int'(done) + int'(busy); end
    chk("calc rst quiet", 64'(seen), 64'd0);

    run_op("post rst", MULTU, 32'h0000FFFF, 32'h00010001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_exe.md
MULDIV_EXE -- requirements
Module: muldiv_exe

Interface
REQ-001 Parameter: none; datapath width is fixed at 32 bits.
REQ-002 clock  in  1  single clock; all state changes on posedge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  launch operation; sampled only in IDLE.
REQ-005 op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_data  in  32  operand A / dividend, from ID/EXE readData1Out.
REQ-007 rt_data  in  32  operand B / divisor, from ID/EXE readData2Out.
REQ-008 cancel  in  1  abort in-flight operation (pipeline flush).
REQ-009 hi_we, lo_we  in  1 each  MTHI/MTLO write strobes.
REQ-010 wdata  in  32  MTHI/MTLO data.
REQ-011 hi, lo  out  32 each  registered HI/LO results (MFHI/MFLO source).
REQ-012 busy  out  1  high whenever state != IDLE; drives pipeline stall.
REQ-013 done  out  1  one-cycle pulse, HI/LO hold the new result.

Function
REQ-014 FSM states IDLE, CALC, FIX; IDLE + start -> CALC; CALC for exactly 32 cycles (5-bit counter 31 down to 0) -> FIX; FIX -> IDLE.
REQ-015 Start sampled at edge N: busy=1 after edges N+1..N+33; HI/LO written and done=1 after edge N+34; busy=0 in that same cycle.
REQ-016 Operands captured at start edge; later changes on rs_data/rt_data have no effect.
REQ-017 Multiply: shift-add on operand magnitudes, one bit per CALC cycle; FIX applies sign for MULT; HI:LO = 64-bit product.
REQ-018 Divide: restoring, one quotient bit per CALC cycle on magnitudes; FIX applies signs for DIV; LO = quotient (truncated toward zero), HI = remainder (sign of dividend).
REQ-019 Divide by zero (DIV/DIVU): full latency; LO=32'hFFFFFFFF, HI=rs_data.
REQ-020 DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
REQ-021 start while busy is ignored; no queuing.
REQ-022 cancel in CALC or FIX: IDLE after next edge, HI/LO unchanged, no done; cancel in IDLE has no effect; cancel wins over FIX completion.
REQ-023 hi_we/lo_we in IDLE without start: hi/lo = wdata after the edge; both may be written in one cycle.
REQ-024 hi_we/lo_we while busy, or coincident with start, are ignored.
REQ-025 done is registered, never asserted two consecutive cycles.

Reset
REQ-026 reset has priority over all inputs: state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0 after the edge.
REQ-027 reset during CALC/FIX discards the operation, no done.

Configuration
REQ-028 Macro MULDIV_DIV_EN: when defined, DIV/DIVU per REQ-018..020.
REQ-029 Without MULDIV_DIV_EN: no divider logic; DIV/DIVU start goes IDLE -> IDLE, busy stays 0, done pulses after edge N+1, HI/LO unchanged.

Structure
REQ-030 Package muldiv_pkg holds op encodings, FSM state encoding, ITER_COUNT=32.
REQ-031 One sub-module muldiv_iter: combinational single-iteration step (add-shift or subtract-restore) instantiated once.

Verification
REQ-032 MULTU FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE, LO=00000001, done exactly 34 cycles after start, busy high 33 cycles.
REQ-033 MULT FFFFFFFD(-3) x 00000007 -> HI=FFFFFFFF, LO=FFFFFFEB.
REQ-034 DIV FFFFFFF9(-7) / 00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 00000064 / 0 -> LO=FFFFFFFF, HI=00000064.
REQ-035 Start MULTU, second start at cycle 5, cancel at cycle 10 -> no done, HI/LO keep prior values, busy low after cycle 11.
REQ-036 MTHI 12345678 in IDLE -> hi=12345678 next cycle; hi_we during busy -> ignored; reset at CALC cycle 20 -> all outputs 0, no done.
